// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back stage and register file.
// Also holds the write-back select encoding used by the control unit.
package wb_regfile_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREGS  = 64;
  localparam int unsigned REG_AW = 6;
  localparam int unsigned CNT_W  = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = 6'd0;

  typedef enum logic [0:0] {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// MEM/WB inputs, ID read ports and WB forwarding/status outputs of wb_regfile.
// The slave modport is the write-back stage; the master is the surrounding pipeline.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic [XLEN-1:0]   mw_read_data;
  logic              mw_mem2reg;
  logic              mw_ctrl_regwr;
  logic [REG_AW-1:0] mw_wr_reg;
  logic [XLEN-1:0]   mw_alu_out;
  logic [REG_AW-1:0] rd_addr_a;
  logic [REG_AW-1:0] rd_addr_b;
  logic [XLEN-1:0]   rd_data_a;
  logic [XLEN-1:0]   rd_data_b;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [CNT_W-1:0]  retire_count;

  modport slave (
    input  mw_read_data, mw_mem2reg, mw_ctrl_regwr, mw_wr_reg, mw_alu_out,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_valid, wb_rd, wb_data, retire_count
  );

  modport master (
    output mw_read_data, mw_mem2reg, mw_ctrl_regwr, mw_wr_reg, mw_alu_out,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_valid, wb_rd, wb_data, retire_count
  );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_regfile_2r1w.sv
// Register storage: 2 async read ports, 1 sync write port, r0 hardwired to zero.
// Define WB_BYPASS_EN to forward the in-flight write to matching read ports.
module regfile_2r1w
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_a_o,
  output logic [XLEN-1:0]   rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-first: a matching read sees the value being committed this cycle.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (wr_en && (raddr_a_i == waddr_i)) rdata_a_o = wdata_i;
    if (wr_en && (raddr_b_i == waddr_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == ZERO_REG) rdata_a_o = '0;
    if (raddr_b_i == ZERO_REG) rdata_b_o = '0;
  end
`else
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_a_i == ZERO_REG) rdata_a_o = '0;
    if (raddr_b_i == ZERO_REG) rdata_b_o = '0;
  end
`endif

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, write qualification, retired-write counter and register file.
// Optional same-cycle read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = wb_regfile_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  wb_sel_e          wb_sel;
  logic [XLEN-1:0]  wb_data_c;
  logic             wb_valid_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wb_sel = wb_sel_e'(bus.mw_mem2reg);

  always_comb begin
    wb_data_c = bus.mw_alu_out;
    if (wb_sel == WB_SEL_MEM) wb_data_c = bus.mw_read_data;
  end

  assign wb_valid_c = bus.mw_ctrl_regwr && (bus.mw_wr_reg != ZERO_REG);

  // Saturating count of committed writes.
  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  regfile_2r1w u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_valid_c),
    .waddr_i   (bus.mw_wr_reg),
    .wdata_i   (wb_data_c),
    .raddr_a_i (bus.rd_addr_a),
    .raddr_b_i (bus.rd_addr_b),
    .rdata_a_o (bus.rd_data_a),
    .rdata_b_o (bus.rd_data_b)
  );

  assign bus.wb_data      = wb_data_c;
  assign bus.wb_valid     = wb_valid_c;
  assign bus.wb_rd        = bus.mw_wr_reg;
  assign bus.retire_count = cnt_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a 32-bit-counter instance for function and a
// 4-bit-counter instance for saturation.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wb_regfile_if #(.CNT_W(32)) bus ();
  wb_regfile_if #(.CNT_W(4))  sbus ();

  wb_regfile #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  wb_regfile #(.CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic regwr, input logic m2r, input logic [5:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem);
    bus.mw_ctrl_regwr = regwr;
    bus.mw_mem2reg    = m2r;
    bus.mw_wr_reg     = rd;
    bus.mw_alu_out    = alu;
    bus.mw_read_data  = mem;
  endtask

  task automatic sdrive(input logic regwr, input logic [5:0] rd, input logic [63:0] alu);
    sbus.mw_ctrl_regwr = regwr;
    sbus.mw_mem2reg    = 1'b0;
    sbus.mw_wr_reg     = rd;
    sbus.mw_alu_out    = alu;
    sbus.mw_read_data  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    bus.rd_addr_a = 6'd0;
    bus.rd_addr_b = 6'd0;
    sdrive(1'b0, 6'd0, 64'd0);
    sbus.rd_addr_a = 6'd0;
    sbus.rd_addr_b = 6'd0;
    step();
    step();
    rst = 1'b0;
    chk("reset_count", 64'(bus.retire_count), 64'd0);

    // Dirty r1 and r2 so the mid-cycle reset has something to clear.
    drive(1'b1, 1'b0, 6'd1, 64'hAA, 64'd0);
    step();
    drive(1'b1, 1'b0, 6'd2, 64'hBB, 64'd0);
    step();
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    bus.rd_addr_a = 6'd1;
    bus.rd_addr_b = 6'd2;
    #1;
    chk("pre_rst_r1", bus.rd_data_a, 64'hAA);
    chk("pre_rst_cnt", 64'(bus.retire_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_a", bus.rd_data_a, 64'd0);
    chk("rst_async_b", bus.rd_data_b, 64'd0);
    chk("rst_async_cnt", 64'(bus.retire_count), 64'd0);
    // A write presented during reset must be dropped.
    drive(1'b1, 1'b0, 6'd3, 64'h77, 64'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    #1;
    chk("rst_cnt_after", 64'(bus.retire_count), 64'd0);
    for (int i = 1; i < 64; i++) begin
      bus.rd_addr_a = 6'(i);
      bus.rd_addr_b = 6'(64 - i);
      #1;
      chk($sformatf("rst_zero_a_r%0d", i), bus.rd_data_a, 64'd0);
      chk($sformatf("rst_zero_b_r%0d", 64 - i), bus.rd_data_b, 64'd0);
    end

    // ALU write-back to r5.
    step();
    drive(1'b1, 1'b0, 6'd5, 64'hDEAD_BEEF_0000_0001, 64'h5555);
    #1;
    chk("alu_wb_data", bus.wb_data, 64'hDEAD_BEEF_0000_0001);
    chk("alu_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("alu_wb_rd", 64'(bus.wb_rd), 64'd5);
    step();
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    bus.rd_addr_a = 6'd5;
    #1;
    chk("alu_r5", bus.rd_data_a, 64'hDEAD_BEEF_0000_0001);
    chk("alu_cnt", 64'(bus.retire_count), 64'd1);

    // Load write-back to r63, with the load data changing late in the cycle.
    drive(1'b1, 1'b1, 6'd63, 64'hFFFF, 64'h0123_4567_89AB_CDEF);
    #1;
    chk("ld_wb_data", bus.wb_data, 64'h0123_4567_89AB_CDEF);
    #5;
    bus.mw_read_data = 64'hCAFE_F00D_1357_9BDF;
    #1;
    chk("ld_wb_late", bus.wb_data, 64'hCAFE_F00D_1357_9BDF);
    step();
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    bus.rd_addr_b = 6'd63;
    #1;
    chk("ld_r63", bus.rd_data_b, 64'hCAFE_F00D_1357_9BDF);
    chk("ld_cnt", 64'(bus.retire_count), 64'd2);

    // Write to r0 is dropped.
    drive(1'b1, 1'b0, 6'd0, 64'h1234, 64'd0);
    #1;
    chk("r0_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("r0_wb_data", bus.wb_data, 64'h1234);
    step();
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    bus.rd_addr_a = 6'd0;
    #1;
    chk("r0_read", bus.rd_data_a, 64'd0);
    chk("r0_cnt", 64'(bus.retire_count), 64'd2);

    // mem2reg with regwr=0: mux visible, no write, no count.
    drive(1'b0, 1'b1, 6'd9, 64'h99, 64'h4242);
    #1;
    chk("nowr_wb_data", bus.wb_data, 64'h4242);
    chk("nowr_wb_valid", 64'(bus.wb_valid), 64'd0);
    step();
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    bus.rd_addr_a = 6'd9;
    #1;
    chk("nowr_r9", bus.rd_data_a, 64'd0);
    chk("nowr_cnt", 64'(bus.retire_count), 64'd2);

    // Same-cycle read/write of r7.
    drive(1'b1, 1'b0, 6'd7, 64'h11, 64'd0);
    step();
    drive(1'b1, 1'b0, 6'd7, 64'h22, 64'd0);
    bus.rd_addr_b = 6'd7;
    #1;
`ifdef WB_BYPASS_EN
    chk("rw_same_cycle", bus.rd_data_b, 64'h22);
`else
    chk("rw_same_cycle", bus.rd_data_b, 64'h11);
`endif
    step();
    drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
    #1;
    chk("rw_next_cycle", bus.rd_data_b, 64'h22);
    chk("rw_cnt", 64'(bus.retire_count), 64'd4);
    bus.rd_addr_a = 6'd5;
    bus.rd_addr_b = 6'd63;
    #1;
    chk("hold_r5", bus.rd_data_a, 64'hDEAD_BEEF_0000_0001);
    chk("hold_r63", bus.rd_data_b, 64'hCAFE_F00D_1357_9BDF);

    // Saturation on the 4-bit counter; invalid writes first.
    sdrive(1'b0, 6'd4, 64'h1);
    step();
    sdrive(1'b1, 6'd0, 64'h2);
    step();
    sdrive(1'b0, 6'd0, 64'h3);
    #1;
    chk("sat_invalid_cnt", 64'(sbus.retire_count), 64'd0);
    for (int i = 1; i <= 17; i++) begin
      sdrive(1'b1, 6'(i), 64'(i));
      step();
      sdrive(1'b0, 6'd0, 64'd0);
      #1;
      if (i == 14) chk("sat_cnt14", 64'(sbus.retire_count), 64'hE);
      if (i == 15) chk("sat_cnt15", 64'(sbus.retire_count), 64'hF);
    end
    chk("sat_cnt17", 64'(sbus.retire_count), 64'hF);
    sbus.rd_addr_a = 6'd17;
    #1;
    chk("sat_r17", sbus.rd_data_a, 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file. It is the consumer end of the MEM/WB pipeline register.
- Each cycle it selects the write-back value (load data or ALU result) from the MEM/WB outputs and commits it to a 64-entry x 64-bit register file on the clock edge.
- It serves two combinational read ports to ID, drives a WB forwarding bus to EX, and keeps a retired-write counter.

Parameters:
- XLEN, 64, data width of registers and write-back path
- NREGS, 64, number of architectural registers; address width is log2(NREGS) = 6
- CNT_W, 32, width of the retired-write counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mw_read_data  in  XLEN  load data from MEM/WB; it may change combinationally within the cycle
- mw_mem2reg  in  1  1 = write back mw_read_data, 0 = write back mw_alu_out
- mw_ctrl_regwr  in  1  register write enable
- mw_wr_reg  in  6  destination register index
- mw_alu_out  in  XLEN  ALU result from MEM/WB
- rd_addr_a  in  6  read port A index
- rd_addr_b  in  6  read port B index
- rd_data_a  out  XLEN  read port A data, combinational
- rd_data_b  out  XLEN  read port B data, combinational
- wb_valid  out  1  a write-back is committing at the next edge this cycle
- wb_rd  out  6  destination of the current write-back
- wb_data  out  XLEN  value of the current write-back, for forwarding to EX
- retire_count  out  CNT_W  count of committed register writes

Behaviour:
- Reset (asynchronous, takes effect immediately on rst=1):
  - all NREGS registers = 0
  - retire_count = 0
  - rd_data_a/b therefore read 0 during reset
- wb_data = mw_mem2reg ? mw_read_data : mw_alu_out. Purely combinational, zero latency.
- wb_valid = mw_ctrl_regwr AND (mw_wr_reg != 0). wb_rd = mw_wr_reg.
- Commit: on the rising clk edge with rst=0 and wb_valid=1, regs[mw_wr_reg] <= wb_data. At most one write per cycle.
- Register 0 is hardwired to zero:
  - writes to index 0 are dropped, with no counter increment
  - reads of index 0 return 0
- Read ports are asynchronous. Without bypass, a read of the register being written in the same cycle returns the OLD value; the new value is visible from the next cycle.
- retire_count increments by 1 on every edge with wb_valid=1. It saturates at all-ones and does not wrap.
- mw_mem2reg=1 with mw_ctrl_regwr=0: no write, no count. wb_data still reflects the mux so forwarding logic can observe it.
- X or unknown on mw_wr_reg while mw_ctrl_regwr=0 must not disturb state.
- Reset asserted mid-stream: any write presented in that cycle is discarded. The first commit after reset release happens on the first edge where rst=0 and wb_valid=1.
- No handshake and no stall input: the stage always accepts. The pipeline bubbles it receives have mw_ctrl_regwr=0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when wb_valid=1 and rd_addr_x == mw_wr_reg, rd_data_x = wb_data in the same cycle (write-first internal bypass). This removes the need for split-phase register file timing. The zero register is still never bypassed.
- Undefined: read-old behaviour as above, and ID-stage hazard logic must cover the WB-to-ID case.

Decomposition:
- Shared package holds:
  - XLEN, NREGS, REG_AW=6
  - ZERO_REG=6'd0
  - the writeback-select encoding (WB_SEL_ALU=0, WB_SEL_MEM=1), also used by the control unit
- One natural sub-module: regfile_2r1w, the storage array with async reset, 2 async read ports, 1 sync write port and optional bypass. The wb_regfile top holds the write-back mux, the wb_valid qualification and the counter.

Test Plan:
- Reset: assert rst mid-cycle -> all rd_data read 0 immediately; retire_count=0; deassert, read r1..r63 -> all 0.
- ALU write-back: mw_ctrl_regwr=1, mw_mem2reg=0, mw_wr_reg=5, mw_alu_out=64'hDEAD_BEEF_0000_0001 -> wb_data equals that value the same cycle; after the edge, rd_addr_a=5 returns it; retire_count=1.
- Load write-back: mw_mem2reg=1, mw_read_data=64'h0123_4567_89AB_CDEF, mw_alu_out=64'hFFFF, mw_wr_reg=63 -> r63 = 64'h0123_4567_89AB_CDEF. Also change mw_read_data late in the cycle -> the final value is committed.
- Zero register: write 64'h1234 to index 0 with regwr=1 -> wb_valid=0, r0 reads 0, retire_count unchanged.
- Same-cycle read/write of r7 (old value 64'h11, new value 64'h22) -> without WB_BYPASS_EN rd_data_b=64'h11, then 64'h22 next cycle; with WB_BYPASS_EN rd_data_b=64'h22 immediately.
- Counter saturation: CNT_W=4, 17 valid writes -> retire_count holds 4'hF. Writes with regwr=0 or rd=0 never count.
